// File: rtl/seq_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, PC select and
// writeback source codes.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALTED = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] WRITE_ALU = 2'b11;
    localparam logic [1:0] WRITE_MEM = 2'b00;
    localparam logic [1:0] WRITE_IMM = 2'b01;
    localparam logic [1:0] WRITE_RES = 2'b10;

endpackage

// File: rtl/wait_timer.sv
// Clearable saturating wait counter; terminal pulses on the increment that
// brings the count up to MAX.
module wait_timer #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic terminal
);
    localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && count != W'(MAX)) begin
            count <= count + W'(1);
        end
    end

    assign terminal = inc && (count == W'(MAX - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the single-datapath CPU.
// Build option SEQ_TIMEOUT_EN: a memory wait of MEM_WAIT_MAX cycles sends the FSM to ERROR.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic [1:0]       dec_write_src,
    input  logic             dec_halt,
    input  logic             dec_branch,
    input  logic             dec_jump,
    input  logic             dec_cpin,
    input  logic             dec_cpout,
    input  logic             br_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_load,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_write,
    output logic [1:0]       reg_write_src,
    output logic             res_write,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);
    // Handshake: imem_req/dmem_req stay high until the matching ready is seen;
    // the transfer completes in the cycle where req and ready are both high.

    state_t           state_q;
    logic             lat_read, lat_write, lat_branch, lat_jump, lat_cpin, lat_cpout;
    logic [1:0]       lat_src;
    logic [CNT_W-1:0] retired_q;
    logic             mem_op;
    logic             timeout;

    if (CNT_W < 1 || MEM_WAIT_MAX < 1) begin : g_bad_params
        $error("instr_sequencer: CNT_W and MEM_WAIT_MAX must be at least 1");
    end

`ifdef SEQ_TIMEOUT_EN
    logic waiting;
    logic ready_now;
    assign waiting   = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign ready_now = (state_q == ST_FETCH) ? imem_ready : dmem_ready;

    // A ready cycle always leaves the wait state, so clearing there also
    // covers the direct MEM->FETCH hop of a store.
    wait_timer #(.MAX(MEM_WAIT_MAX)) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (!waiting || ready_now),
        .inc      (waiting && !ready_now),
        .terminal (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    assign mem_op = lat_read || lat_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            retired_q  <= '0;
            lat_read   <= 1'b0;
            lat_write  <= 1'b0;
            lat_branch <= 1'b0;
            lat_jump   <= 1'b0;
            lat_cpin   <= 1'b0;
            lat_cpout  <= 1'b0;
            lat_src    <= WRITE_MEM;
        end else begin
            if (pc_en && retired_q != {CNT_W{1'b1}}) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            case (state_q)
                ST_IDLE:   if (start) state_q <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_ready)   state_q <= ST_DECODE;
                    else if (timeout) state_q <= ST_ERROR;
                end
                ST_DECODE: begin
                    lat_read   <= dec_mem_read;
                    lat_write  <= dec_mem_write;
                    lat_branch <= dec_branch;
                    lat_jump   <= dec_jump;
                    lat_cpin   <= dec_cpin;
                    lat_cpout  <= dec_cpout;
                    lat_src    <= dec_write_src;
                    if (dec_halt)                          state_q <= ST_HALTED;
                    else if (dec_mem_read && dec_mem_write) state_q <= ST_ERROR;
                    else                                   state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (mem_op)                      state_q <= ST_MEM;
                    else if (lat_jump || lat_branch) state_q <= ST_FETCH;
                    else                             state_q <= ST_WB;
                end
                ST_MEM: begin
                    if (dmem_ready)   state_q <= lat_write ? ST_FETCH : ST_WB;
                    else if (timeout) state_q <= ST_ERROR;
                end
                ST_WB:     state_q <= ST_FETCH;
                default:   state_q <= state_q;
            endcase
        end
    end

    always_comb begin
        imem_req      = 1'b0;
        ir_load       = 1'b0;
        alu_en        = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        reg_write     = 1'b0;
        reg_write_src = WRITE_MEM;
        res_write     = 1'b0;
        pc_en         = 1'b0;
        pc_sel        = PC_NEXT;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ready;
            end
            ST_EXEC: begin
                alu_en = 1'b1;
                if (!mem_op && lat_jump) begin
                    pc_en  = 1'b1;
                    pc_sel = PC_JUMP;
                end else if (!mem_op && lat_branch) begin
                    pc_en  = 1'b1;
                    pc_sel = br_taken ? PC_BRANCH : PC_NEXT;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = lat_write;
                pc_en    = dmem_ready && lat_write;
            end
            ST_WB: begin
                pc_en = 1'b1;
                if (lat_cpin) begin
                    res_write = 1'b1;
                end else if (lat_cpout) begin
                    reg_write     = 1'b1;
                    reg_write_src = WRITE_RES;
                end else begin
                    reg_write     = 1'b1;
                    reg_write_src = lat_src;
                end
            end
            default: ;
        endcase
    end

    assign busy    = !(state_q == ST_IDLE || state_q == ST_HALTED || state_q == ST_ERROR);
    assign done    = (state_q == ST_HALTED) || (state_q == ST_ERROR);
    assign err     = (state_q == ST_ERROR);
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: the driver pushes the expected
// per-cycle control trace, a negedge monitor compares every active cycle.
module tb_instr_sequencer;

    localparam int CNT_W = 16;
    localparam int REC_W = 15;

    logic             clk, reset, start;
    logic             dec_mem_read, dec_mem_write, dec_halt, dec_branch, dec_jump;
    logic             dec_cpin, dec_cpout, br_taken, imem_ready, dmem_ready;
    logic [1:0]       dec_write_src;
    logic             imem_req, ir_load, alu_en, dmem_req, dmem_we, reg_write;
    logic [1:0]       reg_write_src, pc_sel;
    logic             res_write, pc_en, busy, done, err;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    logic [REC_W-1:0] exp_q[$];
    logic [11:0]      act_strobes;
    int               checks = 0;
    int               errors = 0;
    int               exp_ret = 0;

    instr_sequencer #(.CNT_W(CNT_W), .MEM_WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .start(start),
        .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
        .dec_write_src(dec_write_src), .dec_halt(dec_halt),
        .dec_branch(dec_branch), .dec_jump(dec_jump),
        .dec_cpin(dec_cpin), .dec_cpout(dec_cpout), .br_taken(br_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_load(ir_load), .alu_en(alu_en),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
        .reg_write_src(reg_write_src), .res_write(res_write),
        .pc_en(pc_en), .pc_sel(pc_sel), .busy(busy), .done(done), .err(err),
        .state(state), .retired(retired)
    );

    assign act_strobes = {imem_req, ir_load, alu_en, dmem_req, dmem_we, reg_write,
                          reg_write_src, res_write, pc_en, pc_sel};

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [REC_W-1:0] mk(input logic [2:0] st, input logic ireq, il, alu,
                                            dreq, dwe, rw, input logic [1:0] src,
                                            input logic resw, pce, input logic [1:0] psel);
        return {st, ireq, il, alu, dreq, dwe, rw, src, resw, pce, psel};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // monitor: every cycle where the FSM is busy or strobing must match the queue head
    always @(negedge clk) begin
        logic [REC_W-1:0] act;
        logic [REC_W-1:0] e;
        if (!reset && (busy || act_strobes != '0)) begin
            act = {state, act_strobes};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL trace_extra: got %04h expected nothing at %0t", act, $time);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL trace: got %04h expected %04h at %0t", act, e, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called in the first FETCH cycle; leaves the FSM in its next state.
    task automatic run_instr(input logic rd, wr, input logic [1:0] src,
                             input logic halt, br, jmp, cpi, cpo, taken, input int w);
        int n;
        dec_mem_read = rd;  dec_mem_write = wr; dec_write_src = src;
        dec_halt = halt;    dec_branch = br;    dec_jump = jmp;
        dec_cpin = cpi;     dec_cpout = cpo;    br_taken = taken;
        exp_q.push_back(mk(3'd1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
        exp_q.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
        if (halt || (rd && wr)) begin
            n = 2;
        end else begin
            exp_ret++;
            if (rd || wr) begin
                exp_q.push_back(mk(3'd3, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00));
                for (int i = 0; i <= w; i++)
                    exp_q.push_back(mk(3'd4, 0, 0, 0, 1, wr, 0, 2'b00, 0, (wr && i == w), 2'b00));
                if (wr) begin
                    n = 4 + w;
                end else begin
                    exp_q.push_back(mk(3'd5, 0, 0, 0, 0, 0, 1, src, 0, 1, 2'b00));
                    n = 5 + w;
                end
            end else if (jmp) begin
                exp_q.push_back(mk(3'd3, 0, 0, 1, 0, 0, 0, 2'b00, 0, 1, 2'b10));
                n = 3;
            end else if (br) begin
                exp_q.push_back(mk(3'd3, 0, 0, 1, 0, 0, 0, 2'b00, 0, 1, taken ? 2'b01 : 2'b00));
                n = 3;
            end else begin
                exp_q.push_back(mk(3'd3, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00));
                if (cpi)      exp_q.push_back(mk(3'd5, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 2'b00));
                else if (cpo) exp_q.push_back(mk(3'd5, 0, 0, 0, 0, 0, 1, 2'b10, 0, 1, 2'b00));
                else          exp_q.push_back(mk(3'd5, 0, 0, 0, 0, 0, 1, src, 0, 1, 2'b00));
                n = 4;
            end
        end
        for (int c = 0; c < n; c++) begin
            dmem_ready = (c >= 3 && c < 3 + w) ? 1'b0 : 1'b1;
            tick();
        end
        dmem_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_ret = 0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        dec_mem_read = 0; dec_mem_write = 0; dec_write_src = 2'b00; dec_halt = 0;
        dec_branch = 0; dec_jump = 0; dec_cpin = 0; dec_cpout = 0; br_taken = 0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (2) tick();
        chk("reset_state", 32'(state), 0);
        chk("reset_retired", 32'(retired), 0);
        chk("reset_flags", {29'd0, busy, done, err}, 0);
        chk("reset_strobes", 32'(act_strobes), 0);
        reset = 1'b0;

        // directed instruction stream, zero-wait fetch
        start_run();
        run_instr(0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0);  // ALU add
        chk("alu_retired", 32'(retired), 1);
        chk("alu_back_to_fetch", 32'(state), 1);
        run_instr(0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);  // IMM
        chk("imm_retired", 32'(retired), 32'(exp_ret));
        run_instr(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 3);  // load, 3 wait cycles
        chk("load_wait_retired", 32'(retired), 32'(exp_ret));
        run_instr(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0);  // store, zero wait
        run_instr(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2);  // store, 2 wait cycles
        chk("store_retired", 32'(retired), 32'(exp_ret));
        run_instr(0, 0, 2'b11, 0, 1, 0, 0, 0, 1, 0);  // branch taken
        run_instr(0, 0, 2'b11, 0, 1, 0, 0, 0, 0, 0);  // branch not taken
        run_instr(0, 0, 2'b11, 0, 1, 1, 0, 0, 1, 0);  // branch + jump
        run_instr(0, 0, 2'b11, 0, 0, 1, 0, 0, 0, 0);  // jump
        chk("branch_retired", 32'(retired), 32'(exp_ret));
        run_instr(0, 0, 2'b11, 0, 0, 0, 1, 0, 0, 0);  // cpin
        run_instr(0, 0, 2'b11, 0, 0, 0, 0, 1, 0, 0);  // cpout
        run_instr(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);  // load, zero wait
        chk("stream_retired", 32'(retired), 12);

        // halt is terminal; start is ignored
        run_instr(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0);
        chk("halt_state", 32'(state), 6);
        chk("halt_flags", {29'd0, busy, done, err}, 32'b010);
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            tick();
        end
        start = 1'b0;
        chk("halt_sticky", 32'(state), 6);
        chk("halt_retired", 32'(retired), 12);
        do_reset();
        chk("rst_after_halt_state", 32'(state), 0);
        chk("rst_after_halt_retired", 32'(retired), 0);

        // read+write decode is illegal
        start_run();
        run_instr(1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        chk("illegal_state", 32'(state), 7);
        chk("illegal_flags", {29'd0, busy, done, err}, 32'b011);
        chk("illegal_strobes", 32'(act_strobes), 0);
        do_reset();

        // reset while waiting in MEM aborts the load
        start_run();
        dec_mem_read = 1; dec_mem_write = 0; dec_write_src = 2'b00;
        dec_halt = 0; dec_branch = 0; dec_jump = 0; dec_cpin = 0; dec_cpout = 0;
        dmem_ready = 1'b0;
        exp_q.push_back(mk(3'd1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
        exp_q.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
        exp_q.push_back(mk(3'd3, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00));
        exp_q.push_back(mk(3'd4, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 2'b00));
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("mem_abort_state", 32'(state), 0);
        chk("mem_abort_strobes", 32'(act_strobes), 0);
        chk("mem_abort_retired", 32'(retired), 0);
        reset = 1'b0;
        dmem_ready = 1'b1;
        dec_mem_read = 0;

        // instruction memory never ready
        imem_ready = 1'b0;
        start_run();
`ifdef SEQ_TIMEOUT_EN
        for (int i = 0; i < 15; i++)
            exp_q.push_back(mk(3'd1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
        repeat (15) tick();
        chk("timeout_state", 32'(state), 7);
        chk("timeout_flags", {29'd0, busy, done, err}, 32'b011);
        chk("timeout_req_dropped", 32'(act_strobes), 0);
`else
        for (int i = 0; i < 30; i++)
            exp_q.push_back(mk(3'd1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
        repeat (30) tick();
        chk("stall_state", 32'(state), 1);
        chk("stall_err", 32'(err), 0);
`endif
        imem_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle FSM that sequences the single-datapath CPU through fetch, decode, execute, memory and writeback.
- Consumes the decoded control flags from the instruction decoder.
- Drives instruction/data memory handshakes, register/result-register writes and PC update.
- Sits between the decoder and the PC, regfile, ALU and memory enables.

Parameters:
CNT_W, 16, width of retired-instruction counter
MEM_WAIT_MAX, 15, max cycles a memory request may wait for ready (used only with SEQ_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  leave IDLE and begin fetching
dec_mem_read  in  1  decoded load
dec_mem_write  in  1  decoded store
dec_write_src  in  2  decoded writeback source: 11 ALU, 00 MEM, 01 IMM, 10 RES
dec_halt  in  1  decoded halt
dec_branch  in  1  decoded branch
dec_jump  in  1  decoded jump
dec_cpin  in  1  copy register into result register
dec_cpout  in  1  copy result register into register
br_taken  in  1  branch condition from ALU, valid in EXEC
imem_ready  in  1  instruction memory ready
dmem_ready  in  1  data memory ready
imem_req  out  1  instruction fetch request
ir_load  out  1  latch instruction register
alu_en  out  1  ALU operand/result enable
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write
reg_write  out  1  regfile write strobe
reg_write_src  out  2  writeback mux select, same codes as dec_write_src
res_write  out  1  result-register write strobe
pc_en  out  1  PC update strobe
pc_sel  out  2  00 PC+1, 01 branch target, 10 jump target
busy  out  1  state not IDLE/HALTED/ERROR
done  out  1  HALTED or ERROR
err  out  1  ERROR state
state  out  3  current state encoding
retired  out  CNT_W  instructions retired

Behaviour:
- Reset is synchronous and active-high; one clock, clk.
- On reset:
  - state=IDLE; retired=0.
  - All strobes 0; pc_sel=00; reg_write_src=00; busy/done/err=0.
  - Reset mid-instruction aborts with no further strobes.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6, ERROR=7.
- All strobes are combinational from state plus latched flags, and pulse exactly one cycle per instruction unless noted.
- IDLE: start=1 -> FETCH.
- FETCH:
  - imem_req=1 held until imem_ready.
  - In the ready cycle ir_load=1, then -> DECODE.
- DECODE: latch all dec_* flags into internal registers. Next state:
  - dec_halt -> HALTED.
  - dec_mem_read & dec_mem_write both set -> ERROR.
  - Otherwise -> EXEC.
- EXEC: alu_en=1.
  - Memory op -> MEM.
  - jump -> pc_en=1, pc_sel=10, -> FETCH. Jump wins over branch.
  - branch -> pc_en=1, pc_sel = br_taken ? 01 : 00, -> FETCH.
  - Otherwise -> WB.
- MEM:
  - dmem_req=1 held; dmem_we = latched write.
  - On dmem_ready: store -> pc_en=1, pc_sel=00, -> FETCH; load -> WB.
- WB:
  - cpin: res_write=1, reg_write=0.
  - cpout: reg_write=1, reg_write_src=10.
  - Otherwise: reg_write=1, reg_write_src = latched dec_write_src.
  - Always pc_en=1, pc_sel=00, -> FETCH.
- Latency with zero-wait memory: ALU/IMM/cp 4 cycles, load 5, store 4, branch/jump 3.
- retired: increments on every pc_en pulse and saturates at all-ones.
- HALTED/ERROR:
  - Terminal until reset; start ignored; done=1; no strobes.
  - err=1 only in ERROR.
- reg_write_src holds 00 when reg_write=0.

Optional Feature:
SEQ_TIMEOUT_EN
- Defined: a wait counter clears on entry to FETCH/MEM and increments each cycle ready is low. If it reaches MEM_WAIT_MAX without ready -> ERROR next cycle; the request drops.
- Undefined: waits indefinitely, ERROR reachable only via illegal decode.

Decomposition:
- Shared package seq_pkg:
  - state encodings.
  - pc_sel codes (PC_NEXT, PC_BRANCH, PC_JUMP).
  - writeback source codes (WRITE_ALU=11, WRITE_MEM=00, WRITE_IMM=01, WRITE_RES=10).
- Sub-module wait_timer: clearable saturating counter with a terminal flag, instantiated only under SEQ_TIMEOUT_EN.

Test Plan:
- ALU add: reset, start, imem_ready=1 always, dec_write_src=11 -> states 1,2,3,5. reg_write=1 with src 11 in cycle 4, pc_en pulse with pc_sel=00, retired=1.
- Load, dmem_ready low 3 cycles -> dmem_req held 4 cycles, dmem_we=0, then WB reg_write src 00. Total 8 cycles, retired=1.
- Branch: br_taken=1 -> EXEC pc_en with pc_sel=01, no reg_write. Repeat with br_taken=0 -> pc_sel=00. Branch+jump both set -> pc_sel=10.
- cpin then cpout -> first res_write=1 with reg_write=0; second reg_write=1 with src 10.
- Halt decoded -> HALTED, done=1, start pulses ignored for 10 cycles. Reset -> IDLE, retired=0. Reset asserted during MEM -> all strobes 0 next cycle.
- With SEQ_TIMEOUT_EN and MEM_WAIT_MAX=15: imem_ready stuck low -> ERROR after 15 wait cycles, err=1, done=1. Without the macro -> FETCH persists, err=0.
